// File: rtl/fwd_pipe_pkg.sv
// Shared forwarding package: 139-bit big-endian stage packet, field indices and builder.
// Packet layout: [0:127] data, [128:130] latency, [131] wr_en, [132:138] rt.
package fwd_pipe_pkg;

  localparam int unsigned NSTG_DEF = 7;
  localparam int unsigned DATA_W   = 128;
  localparam int unsigned PKT_W    = 139;

  localparam int unsigned DATA_MSB = 0;
  localparam int unsigned DATA_LSB = 127;
  localparam int unsigned LAT_LO   = 128;
  localparam int unsigned LAT_HI   = 130;
  localparam int unsigned WE_BIT   = 131;
  localparam int unsigned RT_LO    = 132;
  localparam int unsigned RT_HI    = 138;

  typedef logic [0:PKT_W-1]  fwd_pkt_t;
  typedef logic [0:DATA_W-1] fwd_data_t;

  function automatic fwd_pkt_t mk_pkt(input fwd_data_t  data,
                                      input logic [0:2] lat,
                                      input logic       we,
                                      input logic [0:6] rt);
    fwd_pkt_t p;
    p                    = '0;
    p[DATA_MSB:DATA_LSB] = data;
    p[LAT_LO:LAT_HI]     = lat;
    p[WE_BIT]            = we;
    p[RT_LO:RT_HI]       = rt;
    return p;
  endfunction

endpackage

// File: rtl/fwd_stage.sv
// One forwarding stage register: shifts the incoming packet and inserts the
// result of latency class K when the incoming packet is a writer of that class.
module fwd_stage
  import fwd_pipe_pkg::*;
#(
  parameter int unsigned K = 1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      adv_i,
  input  logic      kill_i,
  input  logic      match_we_i,
  input  fwd_pkt_t  pkt_i,
  input  logic      res_vld_i,
  input  fwd_data_t res_data_i,
  output fwd_pkt_t  pkt_o,
  output logic      orphan_o
);

  fwd_pkt_t pkt_q;
  fwd_pkt_t pkt_d;
  logic     hit;

  always_comb begin
    hit   = res_vld_i && match_we_i && (pkt_i[LAT_LO:LAT_HI] == 3'(K));
    pkt_d = pkt_q;
    if (adv_i) begin
      pkt_d = pkt_i;
      if (hit) begin
        pkt_d[DATA_MSB:DATA_LSB] = res_data_i;
      end
    end else if (kill_i) begin
      // Held in place: a kill can only drop the write, never move data.
      pkt_d[WE_BIT] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_q <= '0;
    end else begin
      pkt_q <= pkt_d;
    end
  end

  assign pkt_o    = pkt_q;
  assign orphan_o = res_vld_i & ~hit;

endmodule

// File: rtl/fwd_pipe.sv
// Result-forwarding shift pipeline: NSTG forwarding stages plus writeback register.
// Optional whole-pipe stall port is enabled by defining FWD_STALL_EN.
module fwd_pipe
  import fwd_pipe_pkg::*;
#(
  parameter int unsigned NSTG = NSTG_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     iss_vld,
  input  logic                     iss_wr_en,
  input  logic [0:6]               iss_rt,
  input  logic [0:2]               iss_lat,
  input  logic [1:NSTG]            res_vld,
  input  logic [1:NSTG][0:127]     res_data,
  input  logic                     flush,
`ifdef FWD_STALL_EN
  input  logic                     stall,
`endif
  output logic [1:NSTG][0:138]     fw_out,
  output logic [0:138]             wb_out,
  output logic                     res_err
);

  logic      adv;
  fwd_pkt_t  stg_in [1:NSTG];
  fwd_pkt_t  stg_q  [1:NSTG];
  logic [1:NSTG] match_we;
  logic [1:NSTG] orphan;

  fwd_pkt_t  wb_q;
  fwd_pkt_t  wb_d;
  logic      res_err_q;
  logic      res_err_d;

`ifdef FWD_STALL_EN
  assign adv = ~stall;
`else
  assign adv = 1'b1;
`endif

  // Stage 1 matches on the unflushed issue so a flushed lat-1 result is
  // absorbed silently; later stages match on the packet as it moves.
  always_comb begin
    stg_in[1]   = mk_pkt('0, iss_lat, iss_vld & iss_wr_en & ~flush, iss_rt);
    match_we[1] = iss_vld & iss_wr_en;
    for (int unsigned k = 2; k <= NSTG; k++) begin
      stg_in[k]         = stg_q[k-1];
      stg_in[k][WE_BIT] = stg_q[k-1][WE_BIT] & ~(flush && (k == 2));
      match_we[k]       = stg_in[k][WE_BIT];
    end
  end

  genvar g;
  generate
    for (g = 1; g <= NSTG; g++) begin : g_stage
      fwd_stage #(
        .K (g)
      ) u_stage (
        .clk        (clk),
        .reset      (reset),
        .adv_i      (adv),
        .kill_i     ((g == 1) ? flush : 1'b0),
        .match_we_i (match_we[g]),
        .pkt_i      (stg_in[g]),
        .res_vld_i  (res_vld[g]),
        .res_data_i (res_data[g]),
        .pkt_o      (stg_q[g]),
        .orphan_o   (orphan[g])
      );
      assign fw_out[g] = stg_q[g];
    end
  endgenerate

  always_comb begin
    wb_d      = adv ? stg_q[NSTG] : wb_q;
    res_err_d = res_err_q | (adv & (|orphan));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_q      <= '0;
      res_err_q <= 1'b0;
    end else begin
      wb_q      <= wb_d;
      res_err_q <= res_err_d;
    end
  end

  assign wb_out  = wb_q;
  assign res_err = res_err_q;

endmodule

// File: tb/tb_fwd_pipe.sv
// Directed self-checking bench for fwd_pipe; stall scenario runs when FWD_STALL_EN is defined.
module tb_fwd_pipe;

  logic                clk = 1'b0;
  logic                reset;
  logic                iss_vld;
  logic                iss_wr_en;
  logic [0:6]          iss_rt;
  logic [0:2]          iss_lat;
  logic [1:7]          res_vld;
  logic [1:7][0:127]   res_data;
  logic                flush;
`ifdef FWD_STALL_EN
  logic                stall;
`endif
  logic [1:7][0:138]   fw_out;
  logic [0:138]        wb_out;
  logic                res_err;

  int checks = 0;
  int errors = 0;

  logic [0:138] e;
  logic [0:138] ea;
  logic [0:127] d;

  always #5 clk = ~clk;

  fwd_pipe #(
    .NSTG (7)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .iss_vld   (iss_vld),
    .iss_wr_en (iss_wr_en),
    .iss_rt    (iss_rt),
    .iss_lat   (iss_lat),
    .res_vld   (res_vld),
    .res_data  (res_data),
    .flush     (flush),
`ifdef FWD_STALL_EN
    .stall     (stall),
`endif
    .fw_out    (fw_out),
    .wb_out    (wb_out),
    .res_err   (res_err)
  );

  task automatic chk(input string tag, input logic [0:138] obs, input logic [0:138] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_vld   = 1'b0;
    iss_wr_en = 1'b0;
    iss_rt    = '0;
    iss_lat   = '0;
    res_vld   = '0;
    res_data  = '0;
    flush     = 1'b0;
`ifdef FWD_STALL_EN
    stall     = 1'b0;
`endif
  endtask

  task automatic issue(input logic [0:2] lat, input logic [0:6] rt);
    iss_vld   = 1'b1;
    iss_wr_en = 1'b1;
    iss_lat   = lat;
    iss_rt    = rt;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 7; k++) chk($sformatf("rst_fw%0d", k), fw_out[k], '0);
    chk("rst_wb", wb_out, '0);
    chk("rst_err", res_err, 1'b0);

    // Asynchronous reset mid-flight
    issue(3'd3, 7'd3);
    tick();
    idle();
    tick();
    chk("pre_rst_fw2", fw_out[2], {128'h0, 3'd3, 1'b1, 7'd3});
    reset = 1'b1;
    #2;
    chk("async_rst_fw2", fw_out[2], '0);
    chk("async_rst_fw1", fw_out[1], '0);
    chk("async_rst_wb", wb_out, '0);
    #1;
    reset = 1'b0;

    // lat=2, rt=5, result one cycle after issue
    issue(3'd2, 7'd5);
    tick();
    idle();
    chk("l2_fw1", fw_out[1], {128'h0, 3'd2, 1'b1, 7'd5});
    d = {16{8'hA5}};
    e = {d, 3'd2, 1'b1, 7'd5};
    res_vld[2]  = 1'b1;
    res_data[2] = d;
    tick();
    idle();
    chk("l2_fw2", fw_out[2], e);
    tick();
    tick();
    chk("l2_fw4", fw_out[4], e);
    tick();
    tick();
    tick();
    chk("l2_fw7", fw_out[7], e);
    tick();
    chk("l2_wb", wb_out, e);
    chk("l2_err", res_err, 1'b0);

    // Back-to-back lat=1/rt=1 then lat=7/rt=2
    d = {16{8'h3C}};
    ea = {d, 3'd1, 1'b1, 7'd1};
    issue(3'd1, 7'd1);
    res_vld[1]  = 1'b1;
    res_data[1] = d;
    tick();
    res_vld = '0;
    res_data = '0;
    issue(3'd7, 7'd2);
    tick();
    idle();
    chk("b2b_fw1", fw_out[1], {128'h0, 3'd7, 1'b1, 7'd2});
    chk("b2b_fw2", fw_out[2], ea);
    for (int i = 0; i < 5; i++) tick();
    chk("b2b_fw6_nodata", fw_out[6], {128'h0, 3'd7, 1'b1, 7'd2});
    d = {16{8'h96}};
    e = {d, 3'd7, 1'b1, 7'd2};
    res_vld[7]  = 1'b1;
    res_data[7] = d;
    tick();
    idle();
    chk("b2b_fw7", fw_out[7], e);
    chk("b2b_wb_a", wb_out, ea);
    tick();
    chk("b2b_wb_b", wb_out, e);
    chk("b2b_err", res_err, 1'b0);

    // Orphan res_vld[4] while a lat-2 packet enters stage 4
    issue(3'd2, 7'd6);
    tick();
    idle();
    d = {16{8'hC3}};
    e = {d, 3'd2, 1'b1, 7'd6};
    res_vld[2]  = 1'b1;
    res_data[2] = d;
    tick();
    idle();
    tick();
    res_vld[4]  = 1'b1;
    res_data[4] = {16{8'h5A}};
    tick();
    idle();
    chk("orph_fw4", fw_out[4], e);
    chk("orph_err", res_err, 1'b1);
    tick();
    tick();
    tick();
    chk("orph_err_hold", res_err, 1'b1);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    chk("orph_err_clr", res_err, 1'b0);

    // Flush the previous issue together with a concurrent lat-1 issue + result
    issue(3'd3, 7'd9);
    tick();
    issue(3'd1, 7'd10);
    flush       = 1'b1;
    res_vld[1]  = 1'b1;
    res_data[1] = {16{8'h77}};
    tick();
    idle();
    chk("fl_fw2", fw_out[2], {128'h0, 3'd3, 1'b0, 7'd9});
    chk("fl_fw1_we", fw_out[1][131], 1'b0);
    chk("fl_fw1_rt", fw_out[1][132:138], 7'd10);
    chk("fl_err", res_err, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("fl_wb_we_%0d", i), wb_out[131], 1'b0);
    end

`ifdef FWD_STALL_EN
    // Stall three cycles mid-flight: wb latency grows from 7 to 10 edges
    d = {16{8'hE1}};
    e = {d, 3'd1, 1'b1, 7'd4};
    issue(3'd1, 7'd4);
    res_vld[1]  = 1'b1;
    res_data[1] = d;
    tick();
    idle();
    tick();
    tick();
    chk("st_fw3_pre", fw_out[3], e);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("st_fw3_%0d", i), fw_out[3], e);
      chk($sformatf("st_fw4_%0d", i), fw_out[4][131], 1'b0);
    end
    stall = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("st_wb_early", wb_out[131], 1'b0);
    chk("st_fw7", fw_out[7], e);
    tick();
    chk("st_wb", wb_out, e);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
